// File: rtl/coin_acceptor_pkg.sv
// Shared types for the coin acceptor: issued coin codes and acceptor FSM states.
package coin_pkg;

   typedef enum logic [4:0] {
      COIN_NONE = 5'd0,
      COIN_5    = 5'd5,
      COIN_10   = 5'd10
   } coin_t;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      GUARD_WAIT
   } acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor input and coin/reject outputs of the coin acceptor.
// COIN_ACC_TALLY_EN adds the running total and reject count outputs.
interface coin_acceptor_if;
   import coin_pkg::*;

   logic        coin_sense;
   coin_t       coin;
   logic        reject;
   logic        fifo_full;
`ifdef COIN_ACC_TALLY_EN
   logic [15:0] total;
   logic [7:0]  rej_cnt;

   modport slave  (input coin_sense, output coin, reject, fifo_full, total, rej_cnt);
   modport master (output coin_sense, input coin, reject, fifo_full, total, rej_cnt);
`else
   modport slave  (input coin_sense, output coin, reject, fifo_full);
   modport master (output coin_sense, input coin, reject, fifo_full);
`endif

endinterface

// File: rtl/coin_acceptor_fifo.sv
// DEPTH-entry coin FIFO with a fall-through head; pointers carry one extra
// wrap bit so equal low bits distinguish full from empty.
module coin_fifo
   import coin_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  logic  pop,
   input  coin_t din,
   output coin_t head,
   output logic  full,
   output logic  empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   coin_t            mem_q [DEPTH];
   logic [DEPTH-1:0] wr_en;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = do_push && (wr_ptr_q[AW-1:0] == AW'(gi));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) mem_q[i] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes the sensor, measures pulse widths, classifies
// coins into a FIFO and issues them spaced by ISSUE_GAP. Optional tally: COIN_ACC_TALLY_EN.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int W5_LO     = 4,
   parameter int W5_HI     = 8,
   parameter int W10_LO    = 12,
   parameter int W10_HI    = 20,
   parameter int GUARD     = 3,
   parameter int DEPTH     = 4,
   parameter int ISSUE_GAP = 1
)(
   input logic           clk,
   input logic           rst,
   coin_acceptor_if.slave bus
);

   localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             sync1_q, sense_s_q;
   acc_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [GRD_W-1:0] guard_q;
   logic             reject_q;
   logic [GAP_W-1:0] gap_q, gap_d;

   coin_t class_coin, fifo_head, coin_out;
   logic  pulse_end, push, pop, fifo_empty, fifo_full;

   // A saturated count never classifies, even if a band reaches the ceiling.
   always_comb begin
      class_coin = COIN_NONE;
      if (cnt_q != CNT_MAX) begin
         if (cnt_q >= CNT_W'(W5_LO) && cnt_q <= CNT_W'(W5_HI))
            class_coin = COIN_5;
         else if (cnt_q >= CNT_W'(W10_LO) && cnt_q <= CNT_W'(W10_HI))
            class_coin = COIN_10;
      end
   end

   assign pulse_end = (state_q == MEASURE) && !sense_s_q;
   assign push      = pulse_end && (class_coin != COIN_NONE) && !fifo_full;
   assign pop       = !fifo_empty && (gap_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sense_s_q <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         guard_q   <= '0;
         reject_q  <= 1'b0;
      end else begin
         sync1_q   <= bus.coin_sense;
         sense_s_q <= sync1_q;
         reject_q  <= pulse_end && ((class_coin == COIN_NONE) || fifo_full);
         case (state_q)
            IDLE: begin
               if (sense_s_q) begin
                  cnt_q   <= CNT_W'(1);
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (sense_s_q) begin
                  if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
               end else begin
                  guard_q <= GRD_W'(GUARD - 1);
                  state_q <= GUARD_WAIT;
               end
            end
            GUARD_WAIT: begin
               if (guard_q == '0) state_q <= IDLE;
               else               guard_q <= guard_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      gap_d = gap_q;
      if (pop)                gap_d = GAP_W'(ISSUE_GAP);
      else if (gap_q != '0)   gap_d = gap_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) gap_q <= '0;
      else     gap_q <= gap_d;
   end

   coin_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (class_coin),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign coin_out      = pop ? fifo_head : COIN_NONE;
   assign bus.coin      = coin_out;
   assign bus.reject    = reject_q;
   assign bus.fifo_full = fifo_full;

`ifdef COIN_ACC_TALLY_EN
   logic [15:0] total_q;
   logic [7:0]  rej_cnt_q;
   logic [16:0] total_sum;

   assign total_sum = {1'b0, total_q} + 17'(coin_out);

   always_ff @(posedge clk) begin
      if (rst) begin
         total_q   <= '0;
         rej_cnt_q <= '0;
      end else begin
         total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
         if (reject_q && rej_cnt_q != 8'hFF) rej_cnt_q <= rej_cnt_q + 1'b1;
      end
   end

   assign bus.total   = total_q;
   assign bus.rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench: default acceptor (dut_a) plus one with a long issue gap (dut_b)
// used to back up the FIFO.
module tb_coin_acceptor;
   import coin_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coin_acceptor_if bus_a ();
   coin_acceptor_if bus_b ();

   coin_acceptor dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   coin_acceptor #(.ISSUE_GAP(100)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int a5, a10, arej, abad;
   int b5, b10, brej, bbad;
   int b_last, bmin, bmax;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic clear_counts();
      a5 = 0; a10 = 0; arej = 0; abad = 0;
      b5 = 0; b10 = 0; brej = 0; bbad = 0;
      b_last = -1; bmin = 1000000; bmax = 0;
   endtask

   // Advance n cycles, sampling both DUTs at each falling edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (bus_a.coin == COIN_5) a5++;
         else if (bus_a.coin == COIN_10) a10++;
         else if (bus_a.coin !== COIN_NONE) abad++;
         if (bus_a.reject) arej++;
         if (bus_b.coin == COIN_5) b5++;
         else if (bus_b.coin == COIN_10) b10++;
         else if (bus_b.coin !== COIN_NONE) bbad++;
         if (bus_b.reject) brej++;
         if (bus_b.coin != COIN_NONE) begin
            if (b_last >= 0) begin
               if (cyc - b_last < bmin) bmin = cyc - b_last;
               if (cyc - b_last > bmax) bmax = cyc - b_last;
            end
            b_last = cyc;
         end
      end
   endtask

   task automatic pulse_a(input int w, input int tail);
      bus_a.coin_sense = 1'b1;
      run(w);
      bus_a.coin_sense = 1'b0;
      run(tail);
   endtask

   task automatic pulse_b(input int w, input int tail);
      bus_b.coin_sense = 1'b1;
      run(w);
      bus_b.coin_sense = 1'b0;
      run(tail);
   endtask

   int bw [8] = '{3, 4, 8, 9, 11, 12, 20, 21};
   int be [8] = '{0, 5, 5, 0, 0, 10, 10, 0};

   initial begin
      bus_a.coin_sense = 1'b0;
      bus_b.coin_sense = 1'b0;
      clear_counts();

      // Reset state
      run(3);
      check("rst_coin_a", bus_a.coin, 0);
      check("rst_reject_a", bus_a.reject, 0);
      check("rst_full_a", bus_a.fifo_full, 0);
      check("rst_coin_b", bus_b.coin, 0);
      rst = 1'b0;
      run(2);

      // 6-cycle pulse: coin=5 exactly in F+1
      clear_counts();
      bus_a.coin_sense = 1'b1;
      run(6);
      bus_a.coin_sense = 1'b0;
      run(1); check("t1_lat1", bus_a.coin, 0);
      run(1); check("t1_lat2", bus_a.coin, 0);
      run(1); check("t1_lat3", bus_a.coin, 5);
      run(1); check("t1_lat4", bus_a.coin, 0);
      run(10);
      check("t1_n5", a5, 1);
      check("t1_rej", arej, 0);

      // 15-cycle pulse -> 10
      clear_counts();
      pulse_a(15, 12);
      check("t2_n10", a10, 1);
      check("t2_n5", a5, 0);
      check("t2_rej", arej, 0);

      // 10-cycle pulse, between bands
      clear_counts();
      pulse_a(10, 12);
      check("t2_gap_rej", arej, 1);
      check("t2_gap_coin", a5 + a10, 0);

      // saturating 300-cycle pulse, then a 2-cycle pulse
      clear_counts();
      pulse_a(300, 12);
      check("t3_sat_rej", arej, 1);
      check("t3_sat_coin", a5 + a10, 0);
      clear_counts();
      pulse_a(2, 12);
      check("t3_short_rej", arej, 1);
      check("t3_short_coin", a5 + a10, 0);

      // band edges
      for (int i = 0; i < 8; i++) begin
         clear_counts();
         pulse_a(bw[i], 12);
         check($sformatf("bnd%0d_n5", bw[i]), a5, (be[i] == 5) ? 1 : 0);
         check($sformatf("bnd%0d_n10", bw[i]), a10, (be[i] == 10) ? 1 : 0);
         check($sformatf("bnd%0d_rej", bw[i]), arej, (be[i] == 0) ? 1 : 0);
      end
      check("a_bad_codes", abad, 0);

      // Fill dut_b: first coin issues at once, next four fill the FIFO, sixth rejects
      clear_counts();
      for (int k = 0; k < 5; k++) pulse_b(6, 6);
      check("t4_full", bus_b.fifo_full, 1);
      check("t4_pre_rej", brej, 0);
      check("t4_first_issue", b5, 1);
      pulse_b(6, 8);
      check("t4_rej", brej, 1);
      check("t4_full_hold", bus_b.fifo_full, 1);
      run(450);
      check("t4_total5", b5, 5);
      check("t4_min_space", bmin, 101);
      check("t4_max_space", bmax, 101);
      check("t4_drained", bus_b.fifo_full, 0);
      check("t4_bad_codes", bbad + b10, 0);

      // Reset in the middle of a 6-cycle pulse
      clear_counts();
      bus_a.coin_sense = 1'b1;
      run(3);
      rst = 1'b1;
      run(3);
      bus_a.coin_sense = 1'b0;
      run(2);
      rst = 1'b0;
      run(1);
      check("t5_coin", bus_a.coin, 0);
      check("t5_reject", bus_a.reject, 0);
      check("t5_full", bus_a.fifo_full, 0);
      run(15);
      check("t5_no_coin", a5 + a10, 0);
      check("t5_no_rej", arej, 0);

`ifdef COIN_ACC_TALLY_EN
      check("t6_total_rst", bus_a.total, 0);
      pulse_a(6, 12);
      pulse_a(15, 12);
      pulse_a(15, 12);
      pulse_a(2, 12);
      check("t6_total", bus_a.total, 25);
      check("t6_rej_cnt", bus_a.rej_cnt, 1);
      force dut_a.total_q = 16'hFFFC;
      @(posedge clk);
      #1;
      release dut_a.total_q;
      run(1);
      pulse_a(6, 12);
      check("t6_total_sat", bus_a.total, 16'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
